pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer.
- Sits directly upstream of the PC-increment adder:
  - drives PC into the adder's first input, with the adder's second input tied to 4;
  - takes the adder result back as the sequential next PC.
- Selects the next PC among sequential, branch and jump targets.
- Runs a two-phase fetch/execute handshake with instruction memory and presents one instruction at a time to decode.

Parameters:
DATA_WIDTH, 32, width of PC, addresses, instruction word and counter
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
PC_PLUS4_IN  input  DATA_WIDTH  sequential next PC from the increment adder (PC + 4)
BRANCH_TAKEN  input  1  decode/ALU says branch taken for the instruction currently valid
BRANCH_TARGET  input  DATA_WIDTH  branch target address
JUMP  input  1  jump for the instruction currently valid
JUMP_TARGET  input  DATA_WIDTH  jump target address
STALL  input  1  downstream not ready; hold current instruction and PC
IMEM_READY  input  1  instruction memory returns data this cycle
IMEM_RDATA  input  DATA_WIDTH  instruction word from memory
PC  output  DATA_WIDTH  current PC, feeds the adder
IMEM_REQ  output  1  fetch request
IMEM_ADDR  output  DATA_WIDTH  fetch address
INSTR  output  DATA_WIDTH  latched instruction
INSTR_VALID  output  1  INSTR is valid for decode/execute
MISALIGNED  output  1  sticky flag: a redirect target had nonzero bits [1:0]
INSTR_COUNT  output  DATA_WIDTH  number of instructions retired

Behaviour:
- Reset is asynchronous, active-high. While RST=1, and immediately on assertion, registers take these values:
  - state=S_BOOT, PC=RESET_VECTOR, INSTR=0, INSTR_VALID=0, MISALIGNED=0, INSTR_COUNT=0.
  - IMEM_REQ=0 and IMEM_ADDR=RESET_VECTOR, both derived from state and PC.
- Reset mid-fetch or mid-execute abandons the transaction with no further IMEM_REQ.
- IMEM_REQ = (state==S_FETCH). IMEM_ADDR = PC, combinational.
- S_BOOT: exactly one cycle after reset release, then -> S_FETCH.
- S_FETCH:
  - IMEM_REQ held high, IMEM_ADDR stable, until IMEM_READY=1.
  - On that edge: INSTR<=IMEM_RDATA, INSTR_VALID<=1, -> S_EXEC.
  - IMEM_READY may arrive in the first S_FETCH cycle or any later cycle; there is no timeout.
  - STALL is ignored in S_FETCH.
- S_EXEC: INSTR_VALID=1 and INSTR held stable.
  - If STALL=1: stay; PC, INSTR and INSTR_COUNT unchanged; redirect inputs ignored.
  - If STALL=0, on the edge:
    - PC<=next_pc;
    - INSTR_VALID<=0;
    - INSTR_COUNT<=INSTR_COUNT+1, wrapping 2^DATA_WIDTH-1 -> 0;
    - -> S_FETCH.
- next_pc priority, evaluated only in S_EXEC with STALL=0:
  - JUMP=1 -> JUMP_TARGET;
  - else BRANCH_TAKEN=1 -> BRANCH_TARGET;
  - else PC_PLUS4_IN.
  - JUMP and BRANCH_TAKEN both high: jump wins.
- Alignment:
  - If the selected redirect target has bits[1:0]!=0, PC loads the target with bits[1:0] forced to 0, and MISALIGNED<=1.
  - MISALIGNED is sticky until reset.
  - PC_PLUS4_IN is not checked but still loaded with bits[1:0] cleared.
- Wrap-around: PC=32'hFFFF_FFFC with adder output 32'h0000_0000 loads 0; no flag.
- Throughput: minimum 2 cycles per instruction (one S_FETCH with immediate READY, one S_EXEC).
- Latency: first IMEM_REQ in cycle 2 after reset release; first INSTR_VALID in cycle 3 if READY is immediate.
- INSTR_VALID is never high in the same cycle as IMEM_REQ.
- Any state encoding outside the three states -> S_BOOT on the next edge.

Test Plan:
- Reset/boot: RESET_VECTOR=0x0, assert RST, release, IMEM_READY=1 always, IMEM_RDATA=0x2008_0005.
  -> IMEM_REQ=1, IMEM_ADDR=0x0 in cycle 2; INSTR=0x2008_0005, INSTR_VALID=1 in cycle 3; next IMEM_ADDR=0x4.
- Sequential + memory wait: IMEM_READY low for 3 cycles at PC=0x4.
  -> IMEM_REQ held 4 cycles with IMEM_ADDR=0x4; a single INSTR_VALID follows; INSTR_COUNT increments by exactly 1 per executed instruction.
- Redirect priority: in S_EXEC at PC=0x8, JUMP=1 with JUMP_TARGET=0x40, BRANCH_TAKEN=1 with BRANCH_TARGET=0x20.
  -> next IMEM_ADDR=0x40; the branch-only case gives 0x20.
- Stall: STALL=1 for 5 cycles in S_EXEC, with JUMP toggling during the stall.
  -> PC, INSTR and INSTR_COUNT constant, no IMEM_REQ; after STALL=0 the next PC uses inputs from the release cycle only.
- Misaligned/wrap: BRANCH_TARGET=0x0000_0102.
  -> PC=0x100 and MISALIGNED=1, staying 1.
  - Separately, PC=0xFFFF_FFFC with PC_PLUS4_IN=0 -> PC=0, MISALIGNED unchanged.
- Async reset mid-fetch: assert RST between clock edges while IMEM_REQ=1.
  -> IMEM_REQ, INSTR_VALID and INSTR_COUNT go to 0 immediately without waiting for CLK, and PC=RESET_VECTOR.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter register and two-phase fetch/execute sequencer.
// Drives PC to the external +4 adder and selects the next PC among sequential, branch and jump targets.
module pc_fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] PC_PLUS4_IN,
    input  logic                  BRANCH_TAKEN,
    input  logic [DATA_WIDTH-1:0] BRANCH_TARGET,
    input  logic                  JUMP,
    input  logic [DATA_WIDTH-1:0] JUMP_TARGET,
    input  logic                  STALL,
    input  logic                  IMEM_READY,
    input  logic [DATA_WIDTH-1:0] IMEM_RDATA,
    output logic [DATA_WIDTH-1:0] PC,
    output logic                  IMEM_REQ,
    output logic [DATA_WIDTH-1:0] IMEM_ADDR,
    output logic [DATA_WIDTH-1:0] INSTR,
    output logic                  INSTR_VALID,
    output logic                  MISALIGNED,
    output logic [DATA_WIDTH-1:0] INSTR_COUNT
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_count;
    logic                  r_valid;
    logic                  r_mis;

    logic                  w_redirect;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_target_mis;

    // Jump outranks branch; only a redirect target is checked for alignment.
    always_comb begin
        w_redirect   = JUMP | BRANCH_TAKEN;
        w_target     = PC_PLUS4_IN;
        if (JUMP) begin
            w_target = JUMP_TARGET;
        end else if (BRANCH_TAKEN) begin
            w_target = BRANCH_TARGET;
        end
        w_next_pc    = {w_target[DATA_WIDTH-1:2], 2'b00};
        w_target_mis = w_redirect && (w_target[1:0] != 2'b00);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VECTOR;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (IMEM_READY) begin
                        r_instr <= IMEM_RDATA;
                        r_valid <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A stalled instruction holds everything, including the redirect decision.
                    if (!STALL) begin
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                        r_count <= r_count + ONE;
                        if (w_target_mis) begin
                            r_mis <= 1'b1;
                        end
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign PC          = r_pc;
    assign IMEM_REQ    = (r_state == S_FETCH);
    assign IMEM_ADDR   = r_pc;
    assign INSTR       = r_instr;
    assign INSTR_VALID = r_valid;
    assign MISALIGNED  = r_mis;
    assign INSTR_COUNT = r_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot latency, memory wait, redirect table, stall and async reset.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PC_PLUS4_IN;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        JUMP;
    logic [31:0] JUMP_TARGET;
    logic        STALL;
    logic        IMEM_READY;
    logic [31:0] IMEM_RDATA;
    logic [31:0] PC;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        MISALIGNED;
    logic [31:0] INSTR_COUNT;

    logic        p4_ovr;
    logic [31:0] p4_val;

    int n_chk  = 0;
    int n_fail = 0;

    pc_fetch_unit #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .PC_PLUS4_IN(PC_PLUS4_IN),
        .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .JUMP(JUMP), .JUMP_TARGET(JUMP_TARGET), .STALL(STALL),
        .IMEM_READY(IMEM_READY), .IMEM_RDATA(IMEM_RDATA),
        .PC(PC), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .INSTR(INSTR),
        .INSTR_VALID(INSTR_VALID), .MISALIGNED(MISALIGNED), .INSTR_COUNT(INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural +4 adder, with an override to inject odd adder results.
    assign PC_PLUS4_IN = p4_ovr ? p4_val : PC + 32'd4;

    typedef struct {
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        ovr;
        logic [31:0] p4;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] exp_cnt;
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;

        //            jump jt            br   bt            ovr  p4            rdata         exp_pc        mis
        vecs[0] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0000_0020, 1'b0, 32'h0,        32'hA000_0001, 32'h0000_0040, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_0020, 1'b0, 32'h0,        32'hA000_0002, 32'h0000_0020, 1'b0};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,        32'hA000_0003, 32'h0000_0024, 1'b0};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 32'h0,        32'hA000_0004, 32'hFFFF_FFFC, 1'b0};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,        32'hA000_0005, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0000_0023, 1'b0, 32'h0,        32'hA000_0006, 32'h0000_0080, 1'b0};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 32'h0000_0102, 1'b0, 32'h0,        32'hA000_0007, 32'h0000_0100, 1'b1};
        vecs[7] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,        32'hA000_0008, 32'h0000_0104, 1'b1};
        vecs[8] = '{1'b1, 32'h0000_0203, 1'b1, 32'h0000_0020, 1'b0, 32'h0,        32'hA000_0009, 32'h0000_0200, 1'b1};
        vecs[9] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0207, 32'hA000_000A, 32'h0000_0204, 1'b1};

        RST = 1'b1; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0; JUMP = 1'b0; JUMP_TARGET = '0;
        STALL = 1'b0; IMEM_READY = 1'b1; IMEM_RDATA = 32'h2008_0005; p4_ovr = 1'b0; p4_val = '0;
        repeat (3) tick();

        chk("rst_pc", PC, 32'h0);
        chk("rst_req", {31'b0, IMEM_REQ}, 32'h0);
        chk("rst_addr", IMEM_ADDR, 32'h0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_valid", {31'b0, INSTR_VALID}, 32'h0);
        chk("rst_mis", {31'b0, MISALIGNED}, 32'h0);
        chk("rst_cnt", INSTR_COUNT, 32'h0);

        // Boot: cycle 1 idle, cycle 2 request, cycle 3 instruction valid
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("boot_c1_req", {31'b0, IMEM_REQ}, 32'h0);
        tick();
        chk("boot_c2_req", {31'b0, IMEM_REQ}, 32'h1);
        chk("boot_c2_addr", IMEM_ADDR, 32'h0);
        chk("boot_c2_valid", {31'b0, INSTR_VALID}, 32'h0);
        tick();
        chk("boot_c3_valid", {31'b0, INSTR_VALID}, 32'h1);
        chk("boot_c3_instr", INSTR, 32'h2008_0005);
        chk("boot_c3_req", {31'b0, IMEM_REQ}, 32'h0);
        tick();
        chk("seq_addr", IMEM_ADDR, 32'h4);
        chk("seq_cnt", INSTR_COUNT, 32'h1);
        chk("seq_req", {31'b0, IMEM_REQ}, 32'h1);

        // Memory wait: READY low for 3 cycles at PC=0x4
        IMEM_READY = 1'b0;
        IMEM_RDATA = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'b0, IMEM_REQ}, 32'h1);
            chk("wait_addr", IMEM_ADDR, 32'h4);
            chk("wait_valid", {31'b0, INSTR_VALID}, 32'h0);
            tick();
        end
        IMEM_READY = 1'b1;
        chk("wait_req4", {31'b0, IMEM_REQ}, 32'h1);
        chk("wait_addr4", IMEM_ADDR, 32'h4);
        tick();
        chk("wait_valid", {31'b0, INSTR_VALID}, 32'h1);
        chk("wait_instr", INSTR, 32'h1111_1111);
        chk("wait_cnt_hold", INSTR_COUNT, 32'h1);
        tick();
        chk("wait_next_addr", IMEM_ADDR, 32'h8);
        chk("wait_cnt", INSTR_COUNT, 32'h2);
        chk("wait_valid_off", {31'b0, INSTR_VALID}, 32'h0);
        IMEM_RDATA = 32'h2222_2222;
        tick();
        chk("exec8_valid", {31'b0, INSTR_VALID}, 32'h1);
        exp_cnt = 32'h2;

        // Redirect / alignment / wrap table, each entry starts in S_EXEC
        for (int v = 0; v < 10; v++) begin
            JUMP = vecs[v].jump; JUMP_TARGET = vecs[v].jt;
            BRANCH_TAKEN = vecs[v].br; BRANCH_TARGET = vecs[v].bt;
            p4_ovr = vecs[v].ovr; p4_val = vecs[v].p4;
            tick();
            exp_cnt = exp_cnt + 32'd1;
            JUMP = 1'b0; BRANCH_TAKEN = 1'b0; p4_ovr = 1'b0;
            chk($sformatf("vec%0d_addr", v), IMEM_ADDR, vecs[v].exp_pc);
            chk($sformatf("vec%0d_mis", v), {31'b0, MISALIGNED}, {31'b0, vecs[v].exp_mis});
            chk($sformatf("vec%0d_cnt", v), INSTR_COUNT, exp_cnt);
            chk($sformatf("vec%0d_req", v), {31'b0, IMEM_REQ}, 32'h1);
            IMEM_RDATA = vecs[v].rdata;
            tick();
            chk($sformatf("vec%0d_instr", v), INSTR, vecs[v].rdata);
            chk($sformatf("vec%0d_valid", v), {31'b0, INSTR_VALID}, 32'h1);
        end

        // Stall with JUMP toggling; release-cycle inputs alone pick the next PC
        hold_pc = PC;
        hold_instr = INSTR;
        STALL = 1'b1;
        JUMP_TARGET = 32'h0000_0300;
        for (int i = 0; i < 5; i++) begin
            JUMP = (i % 2 == 0);
            tick();
            chk("stall_pc", PC, hold_pc);
            chk("stall_instr", INSTR, hold_instr);
            chk("stall_cnt", INSTR_COUNT, exp_cnt);
            chk("stall_req", {31'b0, IMEM_REQ}, 32'h0);
            chk("stall_valid", {31'b0, INSTR_VALID}, 32'h1);
        end
        STALL = 1'b0;
        JUMP = 1'b0;
        tick();
        exp_cnt = exp_cnt + 32'd1;
        chk("stall_rel_pc", PC, hold_pc + 32'd4);
        chk("stall_rel_cnt", INSTR_COUNT, exp_cnt);

        // Async reset mid-fetch, asserted between clock edges
        IMEM_READY = 1'b0;
        chk("arst_pre_req", {31'b0, IMEM_REQ}, 32'h1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_req", {31'b0, IMEM_REQ}, 32'h0);
        chk("arst_valid", {31'b0, INSTR_VALID}, 32'h0);
        chk("arst_cnt", INSTR_COUNT, 32'h0);
        chk("arst_pc", PC, 32'h0);
        chk("arst_mis", {31'b0, MISALIGNED}, 32'h0);
        IMEM_READY = 1'b1;
        tick();
        tick();
        chk("arst_hold_req", {31'b0, IMEM_REQ}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        chk("reboot_req", {31'b0, IMEM_REQ}, 32'h1);
        chk("reboot_addr", IMEM_ADDR, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
